// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature decoder bank: step-resolution modes,
// the forward-step table and the transition classifier.
package quad_pkg;

  typedef enum logic [1:0] {
    MODE_X4   = 2'b00,
    MODE_X2   = 2'b01,
    MODE_X1   = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    STEP_IDLE,
    STEP_FWD,
    STEP_REV,
    STEP_ILL
  } step_e;

  typedef logic [1:0] ab_t;  // {A,B}

  // Forward direction: 00 -> 10 -> 11 -> 01 -> 00
  function automatic ab_t fwd_next(input ab_t s);
    case (s)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic step_e classify(input ab_t prev, input ab_t cur);
    if (prev == cur)                  return STEP_IDLE;
    else if ((prev ^ cur) == 2'b11)   return STEP_ILL;
    else if (fwd_next(prev) == cur)   return STEP_FWD;
    else                              return STEP_REV;
  endfunction

  // Whether a legal step landing on 'cur' is counted at this resolution.
  function automatic logic step_counted(input mode_e m, input ab_t cur);
    case (m)
      MODE_X2: return cur[1] == cur[0];
      MODE_X1: return cur == 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/quad_channel.sv
// One encoder channel: 2-flop synchroniser, debouncer, transition decoder
// and up/down position counter.
module quad_channel
  import quad_pkg::*;
#(
  parameter int CNT_WIDTH = 8,
  parameter int DEB_BITS  = 11,
  parameter int SATURATE  = 0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 a,
  input  logic                 b,
  input  logic [1:0]           mode,
  input  logic                 clr,
  input  logic                 err_clr,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 up,
  output logic                 down,
  output logic                 err
);

  ab_t                 sync1, sync2, deb, prev;
  logic [DEB_BITS-1:0] deb_cnt [2];

  step_e               step;
  logic                inc, dec, ill;
  logic [CNT_WIDTH-1:0] cnt_next;

  // Index 1 carries A, index 0 carries B, matching the {A,B} pair layout.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= '1;
      sync2 <= '1;
      deb   <= '1;
      for (int unsigned i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= {a, b};
      sync2 <= sync1;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync1[i] != sync2[i])
          deb_cnt[i] <= '0;
        else if (!deb_cnt[i][DEB_BITS-1])
          deb_cnt[i] <= deb_cnt[i] + DEB_BITS'(1);
        if (deb_cnt[i][DEB_BITS-1])
          deb[i] <= sync2[i];
      end
    end
  end

  always_comb begin
    step = classify(prev, deb);
    ill  = (step == STEP_ILL);
    inc  = (step == STEP_FWD) && step_counted(mode_e'(mode), deb);
    dec  = (step == STEP_REV) && step_counted(mode_e'(mode), deb);

    cnt_next = count;
    if (inc) begin
      if (!(SATURATE != 0 && count == '1))
        cnt_next = count + CNT_WIDTH'(1);
    end else if (dec) begin
      if (!(SATURATE != 0 && count == '0))
        cnt_next = count - CNT_WIDTH'(1);
    end
    if (clr)
      cnt_next = '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      prev  <= '1;
      count <= '0;
      up    <= 1'b0;
      down  <= 1'b0;
      err   <= 1'b0;
    end else begin
      prev  <= deb;
      count <= cnt_next;
      up    <= inc;
      down  <= dec;
      if (ill)
        err <= 1'b1;
      else if (err_clr)
        err <= 1'b0;
    end
  end

endmodule

// File: rtl/quad_decoder_bank.sv
// Bank of independent quadrature decoder channels with flattened count bus.
module quad_decoder_bank
  import quad_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int CNT_WIDTH = 8,
  parameter int DEB_BITS  = 11,
  parameter int SATURATE  = 0
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [CHANNELS-1:0]           a,
  input  logic [CHANNELS-1:0]           b,
  input  logic [1:0]                    mode,
  input  logic [CHANNELS-1:0]           clr,
  input  logic [CHANNELS-1:0]           err_clr,
  output logic [CHANNELS*CNT_WIDTH-1:0] count,
  output logic [CHANNELS-1:0]           up,
  output logic [CHANNELS-1:0]           down,
  output logic [CHANNELS-1:0]           err
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    quad_channel #(
      .CNT_WIDTH (CNT_WIDTH),
      .DEB_BITS  (DEB_BITS),
      .SATURATE  (SATURATE)
    ) u_ch (
      .CLK     (CLK),
      .RST     (RST),
      .a       (a[g]),
      .b       (b[g]),
      .mode    (mode),
      .clr     (clr[g]),
      .err_clr (err_clr[g]),
      .count   (count[g*CNT_WIDTH +: CNT_WIDTH]),
      .up      (up[g]),
      .down    (down[g]),
      .err     (err[g])
    );
  end

endmodule

// File: tb/tb_quad_decoder_bank.sv
// Directed bench for quad_decoder_bank: a wrapping and a saturating instance
// share the same stimulus, with DEB_BITS=4 (8-cycle stable window).
module tb_quad_decoder_bank;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  a, b, mode, clr, err_clr;
  logic [15:0] count, count_s;
  logic [1:0]  up, down, err, up_s, down_s, err_s;

  int checks   = 0;
  int failures = 0;
  int up_n [2] = '{0, 0};
  int dn_n [2] = '{0, 0};

  always #5 CLK = ~CLK;

  quad_decoder_bank #(
    .CHANNELS(2), .CNT_WIDTH(8), .DEB_BITS(4), .SATURATE(0)
  ) dut (
    .CLK(CLK), .RST(RST), .a(a), .b(b), .mode(mode), .clr(clr),
    .err_clr(err_clr), .count(count), .up(up), .down(down), .err(err)
  );

  quad_decoder_bank #(
    .CHANNELS(2), .CNT_WIDTH(8), .DEB_BITS(4), .SATURATE(1)
  ) dut_sat (
    .CLK(CLK), .RST(RST), .a(a), .b(b), .mode(mode), .clr(clr),
    .err_clr(err_clr), .count(count_s), .up(up_s), .down(down_s), .err(err_s)
  );

  // Pulse tallies for the wrapping instance, sampled on the falling edge.
  always @(negedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      up_n[i] += int'(up[i]);
      dn_n[i] += int'(down[i]);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic drive(input logic [1:0] av, input logic [1:0] bv);
    a = av;
    b = bv;
    cycles(20);
  endtask

  task automatic clear_all;
    clr = 2'b11;
    cycles(1);
    clr = 2'b00;
    cycles(1);
  endtask

  task automatic test_reset;
    RST = 1'b1; a = 2'b11; b = 2'b11; mode = 2'b00; clr = 2'b00; err_clr = 2'b00;
    cycles(3);
    checks++;
    if (count !== 16'h0000 || up !== 2'b00 || down !== 2'b00 || err !== 2'b00) begin
      failures++;
      $display("FAIL reset_state count=%h up=%b down=%b err=%b, expected all 0", count, up, down, err);
    end
    checks++;
    if (count_s !== 16'h0000 || err_s !== 2'b00) begin
      failures++;
      $display("FAIL reset_state_sat count=%h err=%b, expected 0", count_s, err_s);
    end
    RST = 1'b0;
    cycles(20);
    checks++;
    if (count !== 16'h0000 || err !== 2'b00 || up_n[0] + up_n[1] + dn_n[0] + dn_n[1] != 0) begin
      failures++;
      $display("FAIL reset_release count=%h err=%b pulses=%0d, expected 0/0/0",
               count, err, up_n[0] + up_n[1] + dn_n[0] + dn_n[1]);
    end
  endtask

  task automatic test_x4;
    int u0, d0, u1, d1;
    clear_all();
    u0 = up_n[0]; d0 = dn_n[0]; u1 = up_n[1]; d1 = dn_n[1];
    // ch0 forward 11->01->00->10->11, ch1 reverse 11->10->00->01->11
    drive(2'b10, 2'b01);
    drive(2'b00, 2'b00);
    drive(2'b01, 2'b10);
    drive(2'b11, 2'b11);
    checks++;
    if (count[7:0] !== 8'd4 || up_n[0] - u0 != 4 || dn_n[0] - d0 != 0) begin
      failures++;
      $display("FAIL x4_fwd count=%0d up=%0d down=%0d, expected 4/4/0",
               count[7:0], up_n[0] - u0, dn_n[0] - d0);
    end
    checks++;
    if (count[15:8] !== 8'd252 || dn_n[1] - d1 != 4 || up_n[1] - u1 != 0) begin
      failures++;
      $display("FAIL x4_rev_parallel count=%0d down=%0d up=%0d, expected 252/4/0",
               count[15:8], dn_n[1] - d1, up_n[1] - u1);
    end
    checks++;
    if (count_s[7:0] !== 8'd4 || count_s[15:8] !== 8'd0) begin
      failures++;
      $display("FAIL x4_sat count0=%0d count1=%0d, expected 4/0", count_s[7:0], count_s[15:8]);
    end
    d0 = dn_n[0];
    // ch0 reverse 11->10->00->01->11, ch1 idle
    drive(2'b11, 2'b10);
    drive(2'b10, 2'b10);
    drive(2'b10, 2'b11);
    drive(2'b11, 2'b11);
    checks++;
    if (count[7:0] !== 8'd0 || dn_n[0] - d0 != 4 || count[15:8] !== 8'd252) begin
      failures++;
      $display("FAIL x4_reverse count0=%0d down=%0d count1=%0d, expected 0/4/252",
               count[7:0], dn_n[0] - d0, count[15:8]);
    end
  endtask

  task automatic fwd_cycle_ch0;
    drive(2'b10, 2'b11);
    drive(2'b10, 2'b10);
    drive(2'b11, 2'b10);
    drive(2'b11, 2'b11);
  endtask

  task automatic test_modes;
    int u0;
    clear_all();
    mode = 2'b01;
    cycles(2);
    u0 = up_n[0];
    fwd_cycle_ch0();
    checks++;
    if (count[7:0] !== 8'd2 || up_n[0] - u0 != 2) begin
      failures++;
      $display("FAIL x2_cycle count=%0d up=%0d, expected 2/2", count[7:0], up_n[0] - u0);
    end
    mode = 2'b10;
    cycles(2);
    checks++;
    if (count[7:0] !== 8'd2) begin
      failures++;
      $display("FAIL mode_change_hold count=%0d, expected 2", count[7:0]);
    end
    u0 = up_n[0];
    fwd_cycle_ch0();
    checks++;
    if (count[7:0] !== 8'd3 || up_n[0] - u0 != 1) begin
      failures++;
      $display("FAIL x1_cycle count=%0d up=%0d, expected 3/1", count[7:0], up_n[0] - u0);
    end
    mode = 2'b11;
    fwd_cycle_ch0();
    checks++;
    if (count[7:0] !== 8'd7) begin
      failures++;
      $display("FAIL reserved_mode count=%0d, expected 7", count[7:0]);
    end
    mode = 2'b00;
  endtask

  task automatic test_wrap_sat;
    int d0;
    clear_all();
    d0 = dn_n[0];
    drive(2'b11, 2'b10);
    drive(2'b10, 2'b10);
    drive(2'b10, 2'b11);
    checks++;
    if (count[7:0] !== 8'd253 || dn_n[0] - d0 != 3) begin
      failures++;
      $display("FAIL wrap_down count=%0d down=%0d, expected 253/3", count[7:0], dn_n[0] - d0);
    end
    checks++;
    if (count_s[7:0] !== 8'd0) begin
      failures++;
      $display("FAIL sat_down count=%0d, expected 0", count_s[7:0]);
    end
    drive(2'b11, 2'b11);
    clear_all();
  endtask

  task automatic test_glitch;
    int u0, d0;
    logic [15:0] c0;
    fwd_cycle_ch0();
    c0 = count; u0 = up_n[0]; d0 = dn_n[0];
    a = 2'b10;
    cycles(3);
    a = 2'b11;
    cycles(20);
    checks++;
    if (count !== c0 || up_n[0] != u0 || dn_n[0] != d0 || err !== 2'b00) begin
      failures++;
      $display("FAIL glitch count=%h up=%0d down=%0d err=%b, expected %h/%0d/%0d/00",
               count, up_n[0], dn_n[0], err, c0, u0, d0);
    end
    clear_all();
  endtask

  task automatic test_illegal;
    int  u0, d0;
    logic seen;
    u0 = up_n[0]; d0 = dn_n[0];
    drive(2'b10, 2'b10);  // ch0 11->00
    checks++;
    if (err !== 2'b01 || count[7:0] !== 8'd0 || up_n[0] != u0 || dn_n[0] != d0) begin
      failures++;
      $display("FAIL illegal_set err=%b count=%0d pulses=%0d, expected 01/0/0",
               err, count[7:0], (up_n[0] - u0) + (dn_n[0] - d0));
    end
    err_clr = 2'b01;
    cycles(1);
    checks++;
    if (err[0] !== 1'b0) begin
      failures++;
      $display("FAIL err_clr err0=%b, expected 0", err[0]);
    end
    // err_clr stays asserted across a second illegal step: set must win.
    a = 2'b11; b = 2'b11;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (err[0]) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL illegal_vs_clr err0 seen=%b, expected 1", seen);
    end
    err_clr = 2'b00;
    cycles(2);
    checks++;
    if (err !== 2'b00 || count[7:0] !== 8'd0) begin
      failures++;
      $display("FAIL illegal_after err=%b count=%0d, expected 00/0", err, count[7:0]);
    end
  endtask

  task automatic test_clr_priority;
    logic hit;
    clear_all();
    drive(2'b10, 2'b11);  // ch0 11->01, count 1
    clr = 2'b01;
    a = 2'b10; b = 2'b10; // ch0 01->00 forward with clr held
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge CLK);
      if (up[0]) begin
        hit = 1'b1;
        checks++;
        if (count[7:0] !== 8'd0) begin
          failures++;
          $display("FAIL clr_priority count=%0d up=%b, expected 0/1", count[7:0], up[0]);
        end
      end
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL clr_up_pulse up0 seen=%b, expected 1", hit);
    end
    clr = 2'b00;
    drive(2'b11, 2'b10);
    drive(2'b11, 2'b11);
    checks++;
    if (count[7:0] !== 8'd2) begin
      failures++;
      $display("FAIL clr_resume count=%0d, expected 2", count[7:0]);
    end
  endtask

  task automatic test_rst_mid;
    int u0, d0;
    a = 2'b10; b = 2'b11;  // start ch0 step, interrupt mid-debounce
    cycles(5);
    RST = 1'b1;
    a = 2'b11; b = 2'b11;
    cycles(2);
    checks++;
    if (count !== 16'h0000 || up !== 2'b00 || down !== 2'b00 || err !== 2'b00) begin
      failures++;
      $display("FAIL rst_mid_outputs count=%h up=%b down=%b err=%b, expected all 0",
               count, up, down, err);
    end
    u0 = up_n[0]; d0 = dn_n[0];
    RST = 1'b0;
    cycles(25);
    checks++;
    if (count !== 16'h0000 || err !== 2'b00 || up_n[0] != u0 || dn_n[0] != d0) begin
      failures++;
      $display("FAIL rst_mid_release count=%h err=%b pulses=%0d, expected 0/00/0",
               count, err, (up_n[0] - u0) + (dn_n[0] - d0));
    end
  endtask

  initial begin
    test_reset();
    test_x4();
    test_modes();
    test_wrap_sat();
    test_glitch();
    test_illegal();
    test_clr_priority();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
